// File: rtl/cla_multiword_seq_if.sv
// Operand/result handshake between a client and the word-serial wide adder.
// The client drives the request side; the sequencer returns status and the sum.
interface cla_multiword_seq_if #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) ();
    logic                     start;
    logic [WORDS*WIDTH-1:0]   op_a;
    logic [WORDS*WIDTH-1:0]   op_b;
    logic                     c_in;
    logic                     busy;
    logic                     done;
    logic [WORDS*WIDTH-1:0]   result;
    logic                     c_out;

    modport master (
        output start, op_a, op_b, c_in,
        input  busy, done, result, c_out
    );

    modport slave (
        input  start, op_a, op_b, c_in,
        output busy, done, result, c_out
    );
endinterface

// File: rtl/cla_multiword_seq.sv
// Word-serial sequencer for wide additions on one external WIDTH-bit CLA.
// Operands are walked least-significant word first; the CLA carry of each pass
// feeds the carry-in of the next, and the final word plus carry complete the sum.
module cla_multiword_seq #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    cla_multiword_seq_if.slave bus,
    output logic [WIDTH-1:0] add_1,
    output logic [WIDTH-1:0] add_2,
    output logic             cla_c_in,
    input  logic [WIDTH-1:0] cla_sum,
    input  logic             cla_c_out
);
    localparam int OP_W  = WORDS * WIDTH;
    localparam int LO_W  = (WORDS - 1) * WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [OP_W-1:0]  a_r;
    logic [OP_W-1:0]  b_r;
    logic             carry_q;
    logic [LO_W-1:0]  acc_q;
    logic [OP_W-1:0]  result_q;
    logic             c_out_q;
    logic             done_q;
    logic             accept;
    logic             last_pass;

    // A request is only honoured from IDLE; the top word's pass closes the op.
    assign accept    = (state_q == IDLE) && bus.start;
    assign last_pass = (state_q == RUN) && (idx_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> RUN on a request, RUN -> IDLE after the top word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CLA operand mux, driven purely from registers so each pass is stable.
    always_comb begin
        add_1    = '0;
        add_2    = '0;
        cla_c_in = 1'b0;
        if (state_q == RUN) begin
            cla_c_in = carry_q;
            for (int w = 0; w < WORDS; w++) begin
                if (idx_q == IDX_W'(w)) begin
                    add_1 = a_r[w*WIDTH +: WIDTH];
                    add_2 = b_r[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Operand latch, per-pass accumulation, carry chaining and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_pass;
            if (accept) begin
                a_r     <= bus.op_a;
                b_r     <= bus.op_b;
                carry_q <= bus.c_in;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                carry_q <= cla_c_out;
                idx_q   <= last_pass ? '0 : idx_q + IDX_W'(1);
                for (int w = 0; w < WORDS - 1; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        acc_q[w*WIDTH +: WIDTH] <= cla_sum;
                    end
                end
                if (last_pass) begin
                    result_q <= {cla_sum, acc_q};
                    c_out_q  <= cla_c_out;
                end
            end
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Bench for the word-serial wide adder: a behavioural CLA sits on the adder
// port, and every sum is compared with a plain 65-bit reference addition.
module tb_cla_multiword_seq;
    localparam int WIDTH = 16;
    localparam int WORDS = 4;
    localparam int L     = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] add_1;
    logic [WIDTH-1:0] add_2;
    logic             cla_c_in;
    logic [WIDTH-1:0] cla_sum;
    logic             cla_c_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cla_multiword_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    cla_multiword_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .add_1     (add_1),
        .add_2     (add_2),
        .cla_c_in  (cla_c_in),
        .cla_sum   (cla_sum),
        .cla_c_out (cla_c_out)
    );

    // External CLA stand-in: purely combinational WIDTH-bit adder.
    always_comb begin
        {cla_c_out, cla_sum} = {1'b0, add_1} + {1'b0, add_2} + {{WIDTH{1'b0}}, cla_c_in};
    end

    typedef struct {
        logic [L-1:0] a;
        logic [L-1:0] b;
        logic         cin;
        logic [L-1:0] r;
        logic         co;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [L:0] ref_sum(input logic [L-1:0] a, input logic [L-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + {{L{1'b0}}, cin};
    endfunction

    task automatic check(input string name, input logic [L:0] act, input logic [L:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation from a negedge and wait (bounded) for done.
    // lat counts rising edges after the accepting edge; ctrace records cla_c_in per pass.
    task automatic run_op(input logic [L-1:0] a, input logic [L-1:0] b, input logic cin,
                          output int lat, output logic [WORDS-1:0] ctrace,
                          output logic held_ok, output logic busy0);
        logic [L-1:0] held;
        held     = bus.result;
        held_ok  = 1'b1;
        ctrace   = '0;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.c_in  = cin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy0 = bus.busy;
        lat = 0;
        while (!bus.done && lat < 20) begin
            if (lat < WORDS) ctrace[lat] = cla_c_in;
            if (bus.result !== held) held_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               lat;
        logic [WORDS-1:0] ctr;
        logic             held_ok;
        logic             busy0;
        logic [L:0]       exp;
        logic [L-1:0]     ra;
        logic [L-1:0]     rb;
        logic             rc;
        int               dones;
        logic [L:0]       cap;
        logic [L:0]       q[$];
        int               ndone;
        int               last_i;

        tbl[0] = '{a: 64'd432, b: 64'd765, cin: 1'b1, r: 64'd1198, co: 1'b0};
        tbl[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFE, b: 64'd1, cin: 1'b1, r: 64'd0, co: 1'b1};
        tbl[2] = '{a: 64'h0000_0000_0000_FFFF, b: 64'd1, cin: 1'b0, r: 64'h1_0000, co: 1'b0};
        tbl[3] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b1,
                   r: 64'hFFFF_FFFF_FFFF_FFFF, co: 1'b1};
        tbl[4] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, cin: 1'b0,
                   r: 64'd0, co: 1'b1};
        tbl[5] = '{a: 64'h0000_FFFF_0000_FFFF, b: 64'h0000_0001_0000_0001, cin: 1'b0,
                   r: 64'h0001_0000_0001_0000, co: 1'b0};
        tbl[6] = '{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0FED_CBA9_8765_4321, cin: 1'b0,
                   r: 64'h2222_2222_2222_2211, co: 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.c_in  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset result", bus.result, 0);
        check("reset c_out", bus.c_out, 0);
        check("reset cla_c_in", {add_1, add_2, cla_c_in}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, lat, ctr, held_ok, busy0);
            check($sformatf("tbl%0d latency", i), lat, WORDS);
            check($sformatf("tbl%0d busy", i), busy0, 1);
            check($sformatf("tbl%0d held", i), held_ok, 1);
            check($sformatf("tbl%0d sum", i), {bus.c_out, bus.result}, {tbl[i].co, tbl[i].r});
            if (i == 2) check("tbl2 carry-in trace", ctr, 4'b0010);
            if (i == 1) check("tbl1 carry-in trace", ctr, 4'b1111);
        end

        // Second start two cycles into an operation is ignored.
        bus.op_a  = 64'h0000_0000_0001_0000;
        bus.op_b  = 64'h0000_0000_0002_0003;
        bus.c_in  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        cap   = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                bus.op_a  = 64'hAAAA_AAAA_AAAA_AAAA;
                bus.op_b  = 64'h5555_5555_5555_5555;
                bus.start = 1'b1;
            end
            if (i == 3) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                cap = {bus.c_out, bus.result};
            end
            @(negedge clk);
        end
        check("ignored start done count", dones, 1);
        check("ignored start sum", cap, ref_sum(64'h0000_0000_0001_0000, 64'h0000_0000_0002_0003, 1'b0));

        // Asynchronous reset in the middle of pass 2.
        bus.op_a  = 64'h0123_4567_89AB_CDEF;
        bus.op_b  = 64'h1111_1111_1111_1111;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort result", {bus.c_out, bus.result}, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("abort no done", dones, 0);
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b0, lat, ctr, held_ok, busy0);
        check("after abort latency", lat, WORDS);
        check("after abort sum", {bus.c_out, bus.result},
              ref_sum(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b0));

        // Randomized operations against the reference sum.
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            if (i % 4 == 3) rb = ~ra;
            run_op(ra, rb, rc, lat, ctr, held_ok, busy0);
            exp = ref_sum(ra, rb, rc);
            check($sformatf("rand%0d latency", i), lat, WORDS);
            check($sformatf("rand%0d sum", i), {bus.c_out, bus.result}, exp);
        end

        // Start held high: back-to-back ops with alternating operand styles.
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        bus.op_a  = ra;
        bus.op_b  = rb;
        bus.c_in  = rc;
        bus.start = 1'b1;
        q.push_back(ref_sum(ra, rb, rc));
        ndone  = 0;
        last_i = 0;
        for (int i = 0; i < 60 && ndone < 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                exp = q.pop_front();
                check($sformatf("stream%0d sum", ndone), {bus.c_out, bus.result}, exp);
                if (ndone > 0) check($sformatf("stream%0d period", ndone), i - last_i, WORDS + 1);
                last_i = i;
                ndone++;
                if (ndone < 8) begin
                    ra = {$urandom, $urandom};
                    if (ndone % 2 == 1) begin
                        rb = ~ra;
                        rc = 1'b1;
                    end else begin
                        rb = {$urandom, $urandom};
                        rc = 1'($urandom_range(0, 1));
                    end
                    bus.op_a = ra;
                    bus.op_b = rb;
                    bus.c_in = rc;
                    q.push_back(ref_sum(ra, rb, rc));
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("stream done count", ndone, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
